gpio_bank: RTL and testbench

Parametrised N-pin GPIO bank: per-pin pad drive with pull-up/pull-down resolution, and input synchronisation with an optional glitch filter. It also provides edge-detect interrupt status with write-1-to-clear, and a pad-level scan shift register replacing the single-pin scan mux. It sits between the pinmux/register block and the chip pads; one instance serves a whole port.

---
 rtl/gpio_bank.sv | 136 +++++++++++++
 tb/tb_gpio_bank.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_bank.sv
// gpio_bank: N-pin GPIO bank with pad drive resolution, input synchronisation,
// per-pin glitch filtering, edge-detect interrupt status and a pad scan register.
module gpio_bank #(
    parameter int N    = 8,
    parameter int SYNC = 2,
    parameter int FW   = 4
) (
    input  logic          clk,
    input  logic          rst,
    inout  wire  [N-1:0]  pad,
    input  logic [N-1:0]  dout,
    input  logic [N-1:0]  oe,
    input  logic [N-1:0]  ie,
    input  logic [N-1:0]  pu,
    input  logic [N-1:0]  pd,
    input  logic [N-1:0]  flt_en,
    input  logic [FW-1:0] flt_th,
    input  logic [N-1:0]  rise_en,
    input  logic [N-1:0]  fall_en,
    input  logic [N-1:0]  irq_clr,
    output logic [N-1:0]  din,
    output logic [N-1:0]  irq_st,
    output logic          irq,
    input  logic          sie,
    input  logic          scap,
    input  logic          soe,
    input  logic          si,
    output logic          so
);

    // Raw input, synchroniser chain and filtered data.
    logic [N-1:0] raw;
    logic [N-1:0] sync_reg [SYNC];
    logic [N-1:0] s_vec;
    logic [N-1:0] din_vec;

    // Edge detection and interrupt status.
    logic [N-1:0] dp_reg;
    logic [N-1:0] irq_st_reg;
    logic [N-1:0] set_vec;

    // Scan shift register.
    logic [N-1:0] sr_reg;

    // Pad drive resolution.
    logic [N-1:0] drive_en;
    logic [N-1:0] drive_val;

    // With input disabled the receiver sees the pull-up level, so it is never floating.
    assign raw   = (ie & pad) | (~ie & pu);
    assign s_vec = sync_reg[SYNC-1];

    // Synchroniser: shift each pin's raw level through SYNC flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < SYNC; k++) begin
                sync_reg[k] <= '0;
            end
        end else begin
            sync_reg[0] <= raw;
            for (int k = 1; k < SYNC; k++) begin
                sync_reg[k] <= sync_reg[k-1];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_pin
            logic          din_bit_reg;
            logic [FW-1:0] cnt_reg;
            logic [FW:0]   th_eff;
            logic [FW:0]   cnt_inc;

            // Effective threshold: 1 when the filter is off, and a zero threshold counts as 1.
            always_comb begin
                th_eff  = {1'b0, flt_th};
                if (!flt_en[gi] || (flt_th == '0)) begin
                    th_eff = {{FW{1'b0}}, 1'b1};
                end
                cnt_inc = {1'b0, cnt_reg} + {{FW{1'b0}}, 1'b1};
            end

            // Filter: accept a new level only after it has differed for th consecutive compares.
            always_ff @(posedge clk) begin
                if (rst) begin
                    din_bit_reg <= 1'b0;
                    cnt_reg     <= '0;
                end else if (s_vec[gi] == din_bit_reg) begin
                    cnt_reg <= '0;
                end else if (cnt_inc >= th_eff) begin
                    din_bit_reg <= s_vec[gi];
                    cnt_reg     <= '0;
                end else begin
                    cnt_reg <= cnt_inc[FW-1:0];
                end
            end

            assign din_vec[gi] = din_bit_reg;

            // Output enable selects scan or functional data; otherwise pulls drive a level.
            assign drive_en[gi]  = oe[gi] | pu[gi] | pd[gi];
            assign drive_val[gi] = oe[gi] ? (sie ? sr_reg[gi] : dout[gi]) : pu[gi];
            assign pad[gi]       = drive_en[gi] ? drive_val[gi] : 1'bz;
        end
    endgenerate

    assign set_vec = (din_vec & ~dp_reg & rise_en) | (~din_vec & dp_reg & fall_en);

    // Edge history and sticky status; a new edge wins over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            dp_reg     <= '0;
            irq_st_reg <= '0;
        end else begin
            dp_reg     <= din_vec;
            irq_st_reg <= set_vec | (irq_st_reg & ~irq_clr);
        end
    end

    // Scan register: shift has priority over capture of the filtered inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr_reg <= '0;
        end else if (sie) begin
            sr_reg <= {sr_reg[N-2:0], si};
        end else if (scap) begin
            sr_reg <= din_vec;
        end
    end

    assign din    = din_vec;
    assign irq_st = irq_st_reg;
    assign irq    = |irq_st_reg;
    assign so     = soe & sr_reg[N-1];

endmodule

// File: tb/tb_gpio_bank.sv
// tb_gpio_bank: directed stimulus for gpio_bank with a cycle-level reference
// model that is checked on every falling edge, plus literal spot checks.
module tb_gpio_bank;
    localparam int N    = 8;
    localparam int SYNC = 2;
    localparam int FW   = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  dout, oe, ie, pu, pd, flt_en, rise_en, fall_en, irq_clr;
    logic [FW-1:0] flt_th;
    logic          sie, scap, soe, si;
    wire  [N-1:0]  pad;
    logic [N-1:0]  din, irq_st;
    logic          irq, so;

    // External pad drivers (the outside world).
    logic [N-1:0]  drv_en, drv_val;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < N; gi++) begin : g_ext
        assign pad[gi] = drv_en[gi] ? drv_val[gi] : 1'bz;
    end

    gpio_bank #(.N(N), .SYNC(SYNC), .FW(FW)) dut (
        .clk(clk), .rst(rst), .pad(pad), .dout(dout), .oe(oe), .ie(ie),
        .pu(pu), .pd(pd), .flt_en(flt_en), .flt_th(flt_th),
        .rise_en(rise_en), .fall_en(fall_en), .irq_clr(irq_clr),
        .din(din), .irq_st(irq_st), .irq(irq),
        .sie(sie), .scap(scap), .soe(soe), .si(si), .so(so)
    );

    // Reference model state.
    logic [N-1:0] m_samples [$];   // raw samples, newest first
    logic [N-1:0] m_din, m_prev, m_stat, m_sr;
    int           m_streak [N];    // consecutive compares where s differed from din

    always @(posedge clk) begin : model
        logic [N-1:0] raw_now, s_old, din_old, set_v;
        int th;
        for (int i = 0; i < N; i++) begin
            raw_now[i] = ie[i] ? pad[i] : pu[i];
        end
        if (rst) begin
            m_din  = '0;
            m_prev = '0;
            m_stat = '0;
            m_sr   = '0;
            for (int i = 0; i < N; i++) m_streak[i] = 0;
            m_samples = {};
            for (int k = 0; k < SYNC; k++) m_samples.push_front('0);
        end else begin
            s_old   = m_samples[SYNC-1];
            din_old = m_din;
            for (int i = 0; i < N; i++) begin
                set_v[i] = (din_old[i] && !m_prev[i] && rise_en[i]) ||
                           (!din_old[i] && m_prev[i] && fall_en[i]);
                if (set_v[i]) m_stat[i] = 1'b1;
                else if (irq_clr[i]) m_stat[i] = 1'b0;
            end
            m_prev = din_old;
            for (int i = 0; i < N; i++) begin
                th = (flt_en[i] && flt_th != 0) ? int'(flt_th) : 1;
                if (s_old[i] != din_old[i]) begin
                    m_streak[i] = m_streak[i] + 1;
                    if (m_streak[i] >= th) begin
                        m_din[i]    = s_old[i];
                        m_streak[i] = 0;
                    end
                end else begin
                    m_streak[i] = 0;
                end
            end
            if (sie) m_sr = (m_sr << 1) | {{(N-1){1'b0}}, si};
            else if (scap) m_sr = din_old;
            m_samples.push_front(raw_now);
            void'(m_samples.pop_back());
        end
    end

    task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
        end
    endtask

    // Per-cycle comparison of every observable output against the model.
    always @(negedge clk) begin
        logic [N-1:0] exp_pad, mask;
        if (chk_on) begin
            for (int i = 0; i < N; i++) begin
                mask[i]    = oe[i] || pu[i] || pd[i];
                exp_pad[i] = oe[i] ? (sie ? m_sr[i] : dout[i]) : pu[i];
            end
            cmp("din", 32'(din), 32'(m_din));
            cmp("irq_st", 32'(irq_st), 32'(m_stat));
            cmp("irq", 32'(irq), 32'(m_stat != 0));
            cmp("so", 32'(so), 32'(soe && m_sr[N-1]));
            cmp("pad", 32'(pad & mask), 32'(exp_pad & mask));
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end else begin
            $display("check %s: %0h ok", name, got);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic read_scan(output logic [7:0] v);
        v   = '0;
        sie = 1'b1;
        si  = 1'b0;
        for (int j = 0; j < 8; j++) begin
            v = {v[6:0], so};
            tick(1);
        end
    endtask

    initial begin
        #100000;
        n_bad++;
        $display("FAIL watchdog: got timeout want finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pat;
        logic [7:0] v;
        rst = 1'b1; dout = '0; oe = '0; ie = '1; pu = '0; pd = '0;
        flt_en = '0; flt_th = '0; rise_en = '0; fall_en = '0; irq_clr = '0;
        sie = 1'b0; scap = 1'b0; soe = 1'b1; si = 1'b0;
        drv_en = '1; drv_val = '0;
        tick(2);
        rst = 1'b0;
        chk_on = 1'b1;
        check("rst_din", 32'(din), 32'h0);
        check("rst_irq_st", 32'(irq_st), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        check("rst_so", 32'(so), 32'h0);

        // Pin 3 rises, filter off: din two edges after the first sample.
        drv_val[3] = 1'b1; rise_en[3] = 1'b1;
        tick(1); check("p3_din_e1", 32'(din[3]), 32'h0);
        tick(1); check("p3_din_e2", 32'(din[3]), 32'h0);
        tick(1); check("p3_din_e3", 32'(din[3]), 32'h1);
        check("p3_irq_early", 32'(irq_st[3]), 32'h0);
        tick(1); check("p3_irq_st", 32'(irq_st[3]), 32'h1);
        check("p3_irq", 32'(irq), 32'h1);
        irq_clr[3] = 1'b1; tick(1); irq_clr = '0;
        check("p3_clr", 32'(irq_st[3]), 32'h0);
        check("p3_irq_off", 32'(irq), 32'h0);

        // Pin 0 glitch filter with threshold 4.
        flt_en[0] = 1'b1; flt_th = 4'd4;
        drv_val[0] = 1'b1; tick(3); drv_val[0] = 1'b0;
        tick(8); check("p0_glitch", 32'(din[0]), 32'h0);
        drv_val[0] = 1'b1;
        tick(5); check("p0_k4", 32'(din[0]), 32'h0);
        tick(1); check("p0_k5", 32'(din[0]), 32'h1);

        // Pin 2: falling edge and clear in the same cycle, then a lone clear.
        rise_en[2] = 1'b1; fall_en[2] = 1'b1;
        drv_val[2] = 1'b1; tick(4);
        check("p2_rise_st", 32'(irq_st[2]), 32'h1);
        drv_val[2] = 1'b0; tick(3);
        check("p2_fell", 32'(din[2]), 32'h0);
        irq_clr[2] = 1'b1; tick(1); irq_clr = '0;
        check("p2_set_wins", 32'(irq_st[2]), 32'h1);
        irq_clr[2] = 1'b1; tick(1); irq_clr = '0;
        check("p2_clr_alone", 32'(irq_st[2]), 32'h0);

        // Pin 5 with input disabled: pulls determine the raw level.
        drv_en[5] = 1'b0; ie[5] = 1'b0; pu[5] = 1'b1;
        tick(2); check("p5_pu_e2", 32'(din[5]), 32'h0);
        tick(1); check("p5_pu_e3", 32'(din[5]), 32'h1);
        check("p5_pad_pu", 32'(pad[5]), 32'h1);
        pu[5] = 1'b0; pd[5] = 1'b1;
        tick(3); check("p5_pd", 32'(din[5]), 32'h0);
        check("p5_pad_pd", 32'(pad[5]), 32'h0);
        pd[5] = 1'b0; ie[5] = 1'b1; drv_en[5] = 1'b1; drv_val[5] = 1'b1;
        tick(3); check("p5_released", 32'(din[5]), 32'h1);

        // Scan shift of 0xA5, MSB first, with pads following the register.
        drv_en = '0; oe = '1; dout = '0; sie = 1'b1; soe = 1'b1;
        pat = 8'hA5;
        for (int b = 7; b >= 0; b--) begin
            si = pat[b];
            tick(1);
        end
        check("scan_pad", 32'(pad), 32'hA5);
        read_scan(v);
        check("scan_so", 32'(v), 32'hA5);

        // Capture din into the scan register and shift it out.
        sie = 1'b0; oe = '0; drv_en = '1; drv_val = 8'h3C;
        tick(4); check("cap_din", 32'(din), 32'h3C);
        scap = 1'b1; tick(1); scap = 1'b0;
        read_scan(v);
        check("cap_so", 32'(v), 32'h3C);

        // Reset mid-filter and mid-shift.
        sie = 1'b0;
        drv_val[0] = 1'b1; sie = 1'b1; si = 1'b1;
        tick(3);
        rst = 1'b1; sie = 1'b0; si = 1'b0;
        tick(1); rst = 1'b0;
        check("mid_rst_din", 32'(din), 32'h0);
        check("mid_rst_irq_st", 32'(irq_st), 32'h0);
        check("mid_rst_irq", 32'(irq), 32'h0);
        check("mid_rst_so", 32'(so), 32'h0);
        tick(5); check("post_rst_p0_k4", 32'(din[0]), 32'h0);
        tick(1); check("post_rst_p0_k5", 32'(din[0]), 32'h1);

        tick(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
